// File: rtl/if_id_pkg.sv
// Shared constants for the IF/ID fetch queue.
// NOP encoding, PC step and redirect-target alignment.
package if_id_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int unsigned PC_INC     = 4;
  localparam logic [63:0] ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

endpackage

// File: rtl/if_id_fifo.sv
// Circular queue of {PC, instruction} entries.
// Flush clears pointers and occupancy; storage is left as is.
module if_id_fifo
  import if_id_pkg::*;
#(
  parameter int DW    = 64,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointer and occupancy; flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the tail on push.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/if_id_fetch_queue.sv
// Fetch PC owner feeding a DEPTH-entry IF/ID queue.
// Redirect flushes and reloads; PC_write gates fetch only.
module if_id_fetch_queue
  import if_id_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_INSTR = if_id_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       PCSrc,
  input  logic [XLEN-1:0]            PC_Branch,
  input  logic                       PC_write,
  output logic [XLEN-1:0]            IMEM_ADDR,
  input  logic [31:0]                IMEM_DATA,
  input  logic                       ID_ready,
  output logic                       ID_valid,
  output logic [XLEN-1:0]            PC_ID,
  output logic [31:0]                INSTRUCTION_ID,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       FULL,
  output logic                       EMPTY
);

  localparam int DW = XLEN + 32;
  localparam logic [XLEN-1:0] PC_MASK = ALIGN_MASK[XLEN-1:0];

  logic [XLEN-1:0] pc_q, pc_d;
  logic            push, pop;
  logic [DW-1:0]   head;

  // Handshake decisions; a full queue still accepts when it pops.
  always_comb begin
    pop  = !EMPTY && ID_ready;
    push = PC_write && !PCSrc && (!FULL || pop);
  end

  // Next fetch PC: redirect, advance on push, else hold.
  always_comb begin
    pc_d = pc_q;
    if (PCSrc)     pc_d = PC_Branch & PC_MASK;
    else if (push) pc_d = pc_q + XLEN'(PC_INC);
  end

  // Fetch PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  if_id_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (PCSrc),
    .wdata ({pc_q, IMEM_DATA}),
    .rdata (head),
    .count (COUNT),
    .full  (FULL),
    .empty (EMPTY)
  );

  // Head outputs, forced to a bubble when nothing is queued.
  always_comb begin
    PC_ID          = '0;
    INSTRUCTION_ID = NOP_INSTR;
    if (!EMPTY) begin
      PC_ID          = head[DW-1:32];
      INSTRUCTION_ID = head[31:0];
    end
  end

  assign IMEM_ADDR = pc_q;
  assign ID_valid  = !EMPTY;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed bench for if_id_fetch_queue (DEPTH=4, RESET_PC=0x100).
// IMEM model returns 0xA0000000 | address.
module tb_if_id_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrc;
  logic [31:0] PC_Branch;
  logic        PC_write;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_DATA;
  logic        ID_ready;
  logic        ID_valid;
  logic [31:0] PC_ID;
  logic [31:0] INSTRUCTION_ID;
  logic [2:0]  COUNT;
  logic        FULL;
  logic        EMPTY;

  int n_assert = 0;
  int n_fail   = 0;

  if_id_fetch_queue #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h100)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .PCSrc          (PCSrc),
    .PC_Branch      (PC_Branch),
    .PC_write       (PC_write),
    .IMEM_ADDR      (IMEM_ADDR),
    .IMEM_DATA      (IMEM_DATA),
    .ID_ready       (ID_ready),
    .ID_valid       (ID_valid),
    .PC_ID          (PC_ID),
    .INSTRUCTION_ID (INSTRUCTION_ID),
    .COUNT          (COUNT),
    .FULL           (FULL),
    .EMPTY          (EMPTY)
  );

  always #5 clk = ~clk;

  assign IMEM_DATA = 32'hA000_0000 | IMEM_ADDR;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, IMEM_ADDR, 32'h100);
    chk({tag, "_valid"}, {31'b0, ID_valid}, 32'd0);
    chk({tag, "_instr"}, INSTRUCTION_ID, 32'h13);
    chk({tag, "_pcid"}, PC_ID, 32'h0);
    chk({tag, "_count"}, {29'b0, COUNT}, 32'd0);
    chk({tag, "_empty"}, {31'b0, EMPTY}, 32'd1);
    chk({tag, "_full"}, {31'b0, FULL}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    PCSrc     = 1'b0;
    PC_Branch = '0;
    PC_write  = 1'b0;
    ID_ready  = 1'b0;
    #2;
    chk_reset("rst");
    step();
    step();
    reset    = 1'b0;
    PC_write = 1'b1;

    step();
    chk("fill1_count", {29'b0, COUNT}, 32'd1);
    chk("fill1_pcid", PC_ID, 32'h100);
    chk("fill1_addr", IMEM_ADDR, 32'h104);
    for (int i = 0; i < 5; i++) step();
    chk("full_count", {29'b0, COUNT}, 32'd4);
    chk("full_flag", {31'b0, FULL}, 32'd1);
    chk("full_addr", IMEM_ADDR, 32'h110);
    chk("full_pcid", PC_ID, 32'h100);
    chk("full_instr", INSTRUCTION_ID, 32'hA000_0100);

    ID_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("flow_count", {29'b0, COUNT}, 32'd4);
      chk("flow_pcid", PC_ID, 32'h100 + 32'(4 * k));
      chk("flow_instr", INSTRUCTION_ID, 32'hA000_0100 + 32'(4 * k));
      chk("flow_addr", IMEM_ADDR, 32'h110 + 32'(4 * k));
    end

    PC_write = 1'b0;
    step();
    chk("drain3_count", {29'b0, COUNT}, 32'd3);
    chk("drain3_pcid", PC_ID, 32'h114);
    chk("drain3_addr", IMEM_ADDR, 32'h120);

    PCSrc     = 1'b1;
    PC_Branch = 32'h203;
    PC_write  = 1'b1;
    step();
    chk("redir_count", {29'b0, COUNT}, 32'd0);
    chk("redir_valid", {31'b0, ID_valid}, 32'd0);
    chk("redir_addr", IMEM_ADDR, 32'h200);
    chk("redir_instr", INSTRUCTION_ID, 32'h13);
    chk("redir_pcid", PC_ID, 32'h0);
    PCSrc    = 1'b0;
    ID_ready = 1'b0;
    step();
    chk("redir1_pcid", PC_ID, 32'h200);
    chk("redir1_instr", INSTRUCTION_ID, 32'hA000_0200);
    chk("redir1_count", {29'b0, COUNT}, 32'd1);
    step();
    chk("redir2_count", {29'b0, COUNT}, 32'd2);
    chk("redir2_addr", IMEM_ADDR, 32'h208);

    PC_write = 1'b0;
    ID_ready = 1'b1;
    step();
    chk("hold1_count", {29'b0, COUNT}, 32'd1);
    chk("hold1_pcid", PC_ID, 32'h204);
    chk("hold1_addr", IMEM_ADDR, 32'h208);
    step();
    chk("hold2_empty", {31'b0, EMPTY}, 32'd1);
    chk("hold2_addr", IMEM_ADDR, 32'h208);
    step();
    chk("hold3_empty", {31'b0, EMPTY}, 32'd1);
    chk("hold3_addr", IMEM_ADDR, 32'h208);
    chk("hold3_instr", INSTRUCTION_ID, 32'h13);

    PCSrc     = 1'b1;
    PC_Branch = 32'hFFFF_FFFC;
    step();
    chk("wrap0_addr", IMEM_ADDR, 32'hFFFF_FFFC);
    PCSrc    = 1'b0;
    PC_write = 1'b1;
    ID_ready = 1'b0;
    step();
    chk("wrap_addr", IMEM_ADDR, 32'h0);
    chk("wrap_pcid", PC_ID, 32'hFFFF_FFFC);
    chk("wrap_instr", INSTRUCTION_ID, 32'hFFFF_FFFC);
    step();
    chk("burst_count", {29'b0, COUNT}, 32'd2);

    #3;
    reset = 1'b1;
    #1;
    chk_reset("midrst");
    step();
    chk_reset("midrst_edge");
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
